// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - PRESENT-80 key schedule sequencer
//
// Holds the evolving 80-bit key register and the round counter. It presents
// round keys K1..K32 to the round engine, one per consumed request.
//
// Optional feature macro: KEY_SCHED_RESTORE_EN. When it is defined, a shadow
// copy of the master key allows a restart without reloading key_i.
//
// Ports:
//   clk               in   system clock, rising edge
//   rst               in   synchronous active-high reset
//   key_i       [79:0] in  master key, sampled on key_load_i
//   key_load_i        in   load key_i and start a new schedule
//   round_req_i       in   current round key consumed; advance
//   key_restart_i     in   restart from the shadow key (KEY_SCHED_RESTORE_EN only)
//   round_key_o [63:0] out current round key = key_reg[79:16]
//   round_key_valid_o out  round_key_o valid (RUN state)
//   round_idx_o  [5:0] out index of the current round key, 1..32
//   busy_o            out  schedule in progress (RUN state)
//   done_o            out  all round keys consumed (DONE state)

module key_schedule_ctrl #(
  parameter int ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] key_i,
  input  logic        key_load_i,
  input  logic        round_req_i,
`ifdef KEY_SCHED_RESTORE_EN
  input  logic        key_restart_i,
`endif
  output logic [63:0] round_key_o,
  output logic        round_key_valid_o,
  output logic [5:0]  round_idx_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [79:0] key_q, key_d;
  logic [5:0]  idx_q, idx_d;
  logic [79:0] key_next;

`ifdef KEY_SCHED_RESTORE_EN
  logic [79:0] shadow_q, shadow_d;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // One PRESENT-80 key update step: rotate left by 61, S-box on the top
  // nibble, then fold the 5-bit round counter into bits [19:15].
  function automatic logic [79:0] key_update(input logic [79:0] k,
                                             input logic [4:0]  rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // Single update instance, always fed from the live key register.
  assign key_next = key_update(key_q, idx_q[4:0]);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
`ifdef KEY_SCHED_RESTORE_EN
    shadow_d = shadow_q;
`endif

    // Load has priority over everything but reset; a load in RUN aborts
    // the schedule in progress and drops any coincident request.
    if (key_load_i) begin
      key_d   = key_i;
      idx_d   = 6'd1;
      state_d = RUN;
`ifdef KEY_SCHED_RESTORE_EN
      shadow_d = key_i;
    end else if (key_restart_i && (state_q != IDLE)) begin
      key_d   = shadow_q;
      idx_d   = 6'd1;
      state_d = RUN;
`endif
    end else if ((state_q == RUN) && round_req_i) begin
      // The last key is consumed without another update, so counter
      // value ROUNDS never reaches the datapath.
      if (idx_q == 6'(ROUNDS)) begin
        state_d = DONE;
      end else begin
        key_d = key_next;
        idx_d = idx_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
`ifdef KEY_SCHED_RESTORE_EN
      shadow_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
`ifdef KEY_SCHED_RESTORE_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign round_key_o       = key_q[79:16];
  assign round_idx_o       = idx_q;
  assign busy_o            = (state_q == RUN);
  assign round_key_valid_o = busy_o;
  assign done_o            = (state_q == DONE);

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - self-checking bench for key_schedule_ctrl

module tb_key_schedule_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] key_i;
  logic        key_load_i;
  logic        round_req_i;
  logic        restart;
  logic [63:0] round_key_o;
  logic        round_key_valid_o;
  logic [5:0]  round_idx_o;
  logic        busy_o;
  logic        done_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_schedule_ctrl #(.ROUNDS(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .key_i             (key_i),
    .key_load_i        (key_load_i),
    .round_req_i       (round_req_i),
`ifdef KEY_SCHED_RESTORE_EN
    .key_restart_i     (restart),
`endif
    .round_key_o       (round_key_o),
    .round_key_valid_o (round_key_valid_o),
    .round_idx_o       (round_idx_o),
    .busy_o            (busy_o),
    .done_o            (done_o)
  );

  // Reference model: full table of round keys computed at load time from
  // the PRESENT-80 rules, plus a position in that table.
  logic [3:0]  sbox_t [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic [63:0] rk [1:32];
  int          m_idx;
  bit          m_run, m_done;
  logic [79:0] m_shadow;

  task automatic build_table(input logic [79:0] k0);
    logic [79:0] k;
    k = k0;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = k[79:16];
      k = (k << 61) | (k >> 19);
      k[79:76] = sbox_t[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(i);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_run = 0; m_done = 0; m_shadow = '0;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [63:0] exp_key;
    exp_key = (m_idx == 0) ? 64'h0 : rk[m_idx];
    chk("round_key", 80'(round_key_o), 80'(exp_key));
    chk("round_idx", 80'(round_idx_o), 80'(m_idx));
    chk("valid",     80'(round_key_valid_o), 80'(m_run));
    chk("busy",      80'(busy_o), 80'(m_run));
    chk("done",      80'(done_o), 80'(m_done));
  endtask

  task automatic apply(input logic ld, input logic [79:0] k, input logic rq, input logic rs);
    rst = 1'b0; key_load_i = ld; key_i = k; round_req_i = rq; restart = rs;
    if (ld) begin
      build_table(k); m_shadow = k; m_idx = 1; m_run = 1; m_done = 0;
`ifdef KEY_SCHED_RESTORE_EN
    end else if (rs && (m_run || m_done)) begin
      build_table(m_shadow); m_idx = 1; m_run = 1; m_done = 0;
`endif
    end else if (rq && m_run) begin
      if (m_idx < 32) m_idx++;
      else begin m_run = 0; m_done = 1; end
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset(input int cycles, input logic others);
    rst = 1'b1; key_load_i = others; key_i = {80{others}};
    round_req_i = others; restart = others;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      check_outputs();
    end
  endtask

  initial begin
    rst = 1'b1; key_i = '0; key_load_i = 1'b0; round_req_i = 1'b0; restart = 1'b0;
    model_reset();

    // Reset with all inputs high, then first cycle after release.
    do_reset(2, 1'b1);
    apply(0, 80'h0, 0, 0);

    // Key 0: K1 then K2.
    apply(1, 80'h0, 0, 0);
    chk("k0_K1", 80'(round_key_o), 80'h0);
    apply(0, 80'h0, 1, 0);
    chk("k0_K2", 80'(round_key_o), 80'(64'hC000000000000000));
    chk("k0_idx2", 80'(round_idx_o), 80'd2);

    // Key 0 full schedule with request held high.
    apply(1, 80'h0, 0, 0);
    for (int i = 0; i < 31; i++) apply(0, 80'h0, 1, 0);
    chk("k0_K32", 80'(round_key_o), 80'(64'h6DAB31744F41D700));
    chk("k0_idx32", 80'(round_idx_o), 80'd32);
    apply(0, 80'h0, 1, 0);
    chk("k0_done", 80'(done_o), 80'd1);
    chk("k0_valid_drop", 80'(round_key_valid_o), 80'd0);
    chk("k0_idx_hold", 80'(round_idx_o), 80'd32);
    apply(0, 80'h0, 1, 0);  // request in DONE is ignored

    // All-ones key.
    apply(1, {80{1'b1}}, 0, 0);
    for (int i = 0; i < 31; i++) apply(0, 80'h0, 1, 0);
    chk("k1_K32", 80'(round_key_o), 80'(64'hFE7A548FB60EB167));
    apply(0, 80'h0, 1, 0);

    // Load together with request at idx 10 aborts the schedule.
    apply(1, {$urandom, $urandom, 16'($urandom)}, 0, 0);
    for (int i = 0; i < 9; i++) apply(0, 80'h0, 1, 0);
    chk("abort_pre_idx", 80'(round_idx_o), 80'd10);
    apply(1, 80'h0123456789ABCDEF0123, 1, 0);
    chk("abort_idx", 80'(round_idx_o), 80'd1);
    chk("abort_K1", 80'(round_key_o), 80'(64'h0123456789ABCDEF));

`ifdef KEY_SCHED_RESTORE_EN
    // Restart at idx 20 and replay the whole schedule.
    apply(1, 80'h0, 0, 0);
    for (int i = 0; i < 19; i++) apply(0, 80'h0, 1, 0);
    apply(0, 80'hFFFF, 1, 1);
    chk("restart_K1", 80'(round_key_o), 80'h0);
    chk("restart_idx", 80'(round_idx_o), 80'd1);
    for (int i = 0; i < 32; i++) apply(0, 80'h0, 1, 0);
    chk("restart_done", 80'(done_o), 80'd1);
    apply(0, 80'h0, 0, 1);  // restart from DONE
    do_reset(1, 1'b0);
    apply(0, 80'h0, 0, 1);  // restart in IDLE is ignored
`endif

    // Randomized traffic against the model.
    for (int s = 0; s < 12; s++) begin
      apply(1, {$urandom, $urandom, 16'($urandom)}, 0, 0);
      for (int c = 0; c < 45; c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 2) begin
          do_reset(1, 1'($urandom));
        end else if (r < 5) begin
          apply(1, {$urandom, $urandom, 16'($urandom)}, 1'($urandom), 1'($urandom));
        end else if (r < 9) begin
          apply(0, 80'h0, 1'($urandom), 1'b1);
        end else begin
          apply(0, 80'h0, ($urandom_range(0, 3) != 0), 1'b0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
# key_schedule_ctrl

Sequencer for the PRESENT-80 key schedule: it holds the 80-bit key register, drives the `key_update` datapath with the correct round counter, and hands round keys K1..K32 to the round engine one per request. It sits between the key input of the encryption core and the round datapath. It owns the only copy of the evolving key and the round counter.

## Interface
Parameters:
- `ROUNDS`, 32: number of round keys issued (K1..K32); fixed for PRESENT-80. Other values are unsupported.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `key_i`  in  80  master key, sampled on `key_load_i`
- `key_load_i`  in  1  load `key_i` and start a new schedule
- `round_req_i`  in  1  round key consumed; advance to the next key
- `key_restart_i`  in  1  restart from the stored master key; present only with `KEY_SCHED_RESTORE_EN`
- `round_key_o`  out  64  current round key, equal to `key_reg[79:16]`
- `round_key_valid_o`  out  1  `round_key_o` is valid
- `round_idx_o`  out  6  index of the current round key, 1..32
- `busy_o`  out  1  schedule in progress (RUN state)
- `done_o`  out  1  all 32 keys consumed; held until the next load or restart

## Operation
- Key register update uses the `key_update` function: rotate left 61, S-box on `[79:76]`, XOR `round_idx_o[4:0]` into `[19:15]`. Counter values 1..31 are used. It is instantiated once and fed from `key_reg`.
- States:
  - IDLE, entered from reset.
  - RUN, `round_key_valid_o`=1.
  - DONE, `done_o`=1.
- IDLE/DONE/RUN with `key_load_i`=1:
  - `key_reg` <= `key_i`, `round_idx_o` <= 1.
  - Go to RUN; `done_o` clears.
- RUN with `round_req_i`=1 and `round_idx_o` < 32:
  - `key_reg` <= `key_update(key_reg, round_idx_o[4:0])`.
  - `round_idx_o` <= `round_idx_o` + 1.
- RUN with `round_req_i`=1 and `round_idx_o` = 32:
  - Go to DONE; `round_key_valid_o` drops.
  - `key_reg` and `round_idx_o` hold (idx stays 32). No update uses counter 32.
- `round_req_i` outside RUN is ignored.
- Simultaneous `key_load_i` and `round_req_i`: load wins and the request is discarded. This means a load aborts a schedule in progress.
- Reset values: state IDLE, `key_reg`=0, `round_key_o`=0, `round_idx_o`=0, `round_key_valid_o`=0, `busy_o`=0, `done_o`=0.
- Reset mid-schedule returns to the reset values on the next edge, regardless of any other input.
- `busy_o` = (state==RUN); `round_key_valid_o` = `busy_o`.

## Timing
- Load at edge t: K1 on `round_key_o` with `round_key_valid_o`=1 after edge t; `round_idx_o`=1.
- Request sampled at edge t with idx=i<32: K(i+1) valid after edge t. Throughput is one round key per cycle with `round_req_i` held high.
- Minimum schedule: 1 load cycle + 32 request cycles. `done_o` rises the cycle after the 32nd request.
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.

## Configuration
- `KEY_SCHED_RESTORE_EN` defined:
  - An 80-bit shadow register captures `key_i` on every load.
  - `key_restart_i`=1 in RUN or DONE reloads `key_reg` from the shadow and sets idx=1, state RUN. It has the same timing as a load.
  - `key_restart_i` in IDLE is ignored.
  - Priority: `rst` > `key_load_i` > `key_restart_i` > `round_req_i`.
  - The shadow register resets to 0.
- Not defined: no shadow register and no `key_restart_i` port. A new schedule requires `key_load_i`.

## Test plan
- Reset with all inputs high for 2 cycles -> all outputs 0 and state IDLE, both during reset and on the first cycle after it.
- Load key 0, then one request -> K1=0x0000000000000000 with idx 1, then K2=0xC000000000000000 with idx 2.
- Load key 0, then `round_req_i` held high for 32 cycles -> K32=0x6DAB31744F41D700 at idx 32, then `done_o`=1, valid=0, idx stays 32.
- Load key all-ones and consume all 32 keys -> every key matches the golden model; K32=0xFE7A548FB60EB167.
- `key_load_i` asserted together with `round_req_i` at idx 10 -> the request is discarded, the new K1 appears next cycle, idx=1.
- With `KEY_SCHED_RESTORE_EN`: load key 0, advance to idx 20, pulse `key_restart_i` -> K1=0x0000000000000000 with idx 1, and a full replay matches the first run.
